// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: owns the architectural fetch PC, issues in-order imem reads under a
// credit limit, and buffers returned instructions; a redirect flushes wrong-path work.
module pc_fetch_unit #(
   parameter logic [63:0] RESET_PC = 64'h0,
   parameter int          DEPTH    = 2
) (
   input  logic        CLK,
   input  logic        Reset_L,
   input  logic [63:0] NextPC,
   input  logic        Redirect,
   output logic        ImemReqValid,
   output logic [63:0] ImemReqAddr,
   input  logic        ImemReqReady,
   input  logic        ImemRespValid,
   input  logic [31:0] ImemRespData,
   output logic        InstrValid,
   output logic [31:0] Instr,
   output logic [63:0] InstrPC,
   input  logic        InstrReady,
   output logic [63:0] CurrentPC
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [PW-1:0] PTR_ONE = PW'(1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);

   typedef enum logic [0:0] {FETCH = 1'b0, FLUSH = 1'b1} state_t;

   state_t        state_r;
   logic [63:0]   fetch_pc_r;
   logic [CW-1:0] outstanding_r;
   logic [CW-1:0] buf_count_r;
   logic [PW-1:0] buf_head_r;
   logic [PW-1:0] buf_tail_r;
   logic [PW-1:0] pend_head_r;
   logic [PW-1:0] pend_tail_r;
   logic [31:0]   buf_instr_r [DEPTH];
   logic [63:0]   buf_pc_r    [DEPTH];
   logic [63:0]   pend_pc_r   [DEPTH];

   logic [CW:0]   used_s;
   logic          credit_s;
   logic          req_valid_s;
   logic          accept_s;
   logic          resp_s;
   logic          push_s;
   logic          pop_s;
   logic          instr_valid_s;
   logic [CW-1:0] out_next_s;
   logic [CW-1:0] cnt_next_s;

   // Slots already promised to in-flight reads count against buffer space.
   assign used_s        = {1'b0, outstanding_r} + {1'b0, buf_count_r};
   assign credit_s      = (used_s < DEPTH_W);
   assign req_valid_s   = Reset_L & (state_r == FETCH) & credit_s & ~Redirect;
   assign accept_s      = req_valid_s & ImemReqReady;
   assign resp_s        = ImemRespValid & (outstanding_r != {CW{1'b0}});
   assign instr_valid_s = (buf_count_r != {CW{1'b0}});
   assign push_s        = resp_s & (state_r == FETCH) & ~Redirect;
   assign pop_s         = instr_valid_s & InstrReady & ~Redirect;

   assign ImemReqValid  = req_valid_s;
   assign ImemReqAddr   = fetch_pc_r;
   assign CurrentPC     = fetch_pc_r;
   assign InstrValid    = instr_valid_s;
   assign Instr         = instr_valid_s ? buf_instr_r[buf_head_r] : 32'h0;
   assign InstrPC       = instr_valid_s ? buf_pc_r[buf_head_r] : 64'h0;

   // Outstanding-request count after this cycle's accept and response.
   always_comb begin
      out_next_s = outstanding_r;
      if (accept_s && !resp_s) begin
         out_next_s = outstanding_r + CNT_ONE;
      end else if (resp_s && !accept_s) begin
         out_next_s = outstanding_r - CNT_ONE;
      end else begin
         out_next_s = outstanding_r;
      end
   end

   // Buffer occupancy after this cycle's push and pop.
   always_comb begin
      cnt_next_s = buf_count_r;
      if (push_s && !pop_s) begin
         cnt_next_s = buf_count_r + CNT_ONE;
      end else if (pop_s && !push_s) begin
         cnt_next_s = buf_count_r - CNT_ONE;
      end else begin
         cnt_next_s = buf_count_r;
      end
   end

   // Fetch FSM, PC, pending-PC queue and instruction buffer.
   always_ff @(posedge CLK or negedge Reset_L) begin
      if (!Reset_L) begin
         state_r       <= FETCH;
         fetch_pc_r    <= RESET_PC;
         outstanding_r <= {CW{1'b0}};
         buf_count_r   <= {CW{1'b0}};
         buf_head_r    <= {PW{1'b0}};
         buf_tail_r    <= {PW{1'b0}};
         pend_head_r   <= {PW{1'b0}};
         pend_tail_r   <= {PW{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            buf_instr_r[i] <= 32'h0;
            buf_pc_r[i]    <= 64'h0;
            pend_pc_r[i]   <= 64'h0;
         end
      end else begin
         outstanding_r <= out_next_s;
         if (Redirect) begin
            // Redirect wins over everything; wrong-path responses still drain in FLUSH.
            fetch_pc_r  <= NextPC & ~64'h3;
            buf_count_r <= {CW{1'b0}};
            buf_head_r  <= {PW{1'b0}};
            buf_tail_r  <= {PW{1'b0}};
            pend_head_r <= {PW{1'b0}};
            pend_tail_r <= {PW{1'b0}};
            state_r     <= (out_next_s != {CW{1'b0}}) ? FLUSH : FETCH;
         end else begin
            case (state_r)
               FETCH: begin
                  if (accept_s) begin
                     fetch_pc_r             <= fetch_pc_r + 64'd4;
                     pend_pc_r[pend_tail_r] <= fetch_pc_r;
                     pend_tail_r            <= pend_tail_r + PTR_ONE;
                  end
                  if (push_s) begin
                     buf_instr_r[buf_tail_r] <= ImemRespData;
                     buf_pc_r[buf_tail_r]    <= pend_pc_r[pend_head_r];
                     buf_tail_r              <= buf_tail_r + PTR_ONE;
                     pend_head_r             <= pend_head_r + PTR_ONE;
                  end
                  if (pop_s) begin
                     buf_head_r <= buf_head_r + PTR_ONE;
                  end
                  buf_count_r <= cnt_next_s;
                  state_r     <= FETCH;
               end
               FLUSH: begin
                  state_r <= (out_next_s == {CW{1'b0}}) ? FETCH : FLUSH;
               end
               default: begin
                  state_r <= FETCH;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: an in-order imem model answers accepted reads when
// enabled; each task checks hand-derived cycle-by-cycle expectations.
module tb_pc_fetch_unit;
   logic        CLK = 1'b0;
   logic        Reset_L;
   logic [63:0] NextPC;
   logic        Redirect;
   logic        ImemReqValid;
   logic [63:0] ImemReqAddr;
   logic        ImemReqReady;
   logic        ImemRespValid;
   logic [31:0] ImemRespData;
   logic        InstrValid;
   logic [31:0] Instr;
   logic [63:0] InstrPC;
   logic        InstrReady;
   logic [63:0] CurrentPC;

   int          errors = 0;
   int          checks = 0;
   logic [63:0] q[$];
   logic        resp_en;

   always #5 CLK = ~CLK;

   pc_fetch_unit #(.RESET_PC(64'h0), .DEPTH(2)) dut (
      .CLK(CLK), .Reset_L(Reset_L), .NextPC(NextPC), .Redirect(Redirect),
      .ImemReqValid(ImemReqValid), .ImemReqAddr(ImemReqAddr), .ImemReqReady(ImemReqReady),
      .ImemRespValid(ImemRespValid), .ImemRespData(ImemRespData),
      .InstrValid(InstrValid), .Instr(Instr), .InstrPC(InstrPC), .InstrReady(InstrReady),
      .CurrentPC(CurrentPC)
   );

   // One clock: sample handshakes mid-cycle, then update the imem model after the edge.
   task automatic cycle();
      logic        acc;
      logic        rsp;
      logic [63:0] a;
      @(negedge CLK);
      acc = ImemReqValid & ImemReqReady;
      a   = ImemReqAddr;
      rsp = ImemRespValid;
      @(posedge CLK);
      #1;
      if (rsp && q.size() != 0) void'(q.pop_front());
      if (acc) q.push_back(a);
      ImemRespValid = resp_en && (q.size() != 0);
      ImemRespData  = (q.size() != 0) ? (32'h1300_0000 | q[0][31:0]) : 32'h0;
   endtask

   task automatic do_reset();
      Reset_L = 1'b0;
      q.delete();
      ImemRespValid = 1'b0;
      cycle();
      cycle();
   endtask

   task automatic test_reset();
      Reset_L = 1'b0; NextPC = 64'h0; Redirect = 1'b0; ImemReqReady = 1'b1;
      ImemRespValid = 1'b0; ImemRespData = 32'h0; InstrReady = 1'b0; resp_en = 1'b0;
      #2;
      checks++; if (ImemReqValid !== 1'b0) begin errors++; $display("FAIL rst_req_valid got %b want 0", ImemReqValid); end
      checks++; if (InstrValid !== 1'b0) begin errors++; $display("FAIL rst_instr_valid got %b want 0", InstrValid); end
      checks++; if (Instr !== 32'h0) begin errors++; $display("FAIL rst_instr got %h want 0", Instr); end
      checks++; if (InstrPC !== 64'h0) begin errors++; $display("FAIL rst_instr_pc got %h want 0", InstrPC); end
      checks++; if (CurrentPC !== 64'h0) begin errors++; $display("FAIL rst_current_pc got %h want 0", CurrentPC); end
      cycle();
      cycle();
      checks++; if (ImemReqValid !== 1'b0) begin errors++; $display("FAIL rst_held_req_valid got %b want 0", ImemReqValid); end
   endtask

   task automatic test_stream();
      logic [63:0] exp_a;
      logic [63:0] exp_p;
      resp_en = 1'b1; InstrReady = 1'b1; ImemReqReady = 1'b1;
      Reset_L = 1'b1;
      #1;
      checks++; if (ImemReqValid !== 1'b1 || ImemReqAddr !== 64'h0) begin errors++; $display("FAIL s0_req got %b/%h want 1/0", ImemReqValid, ImemReqAddr); end
      checks++; if (InstrValid !== 1'b0) begin errors++; $display("FAIL s0_instr_valid got %b want 0", InstrValid); end
      cycle(); #1;
      checks++; if (ImemReqValid !== 1'b1 || ImemReqAddr !== 64'h4) begin errors++; $display("FAIL s1_req got %b/%h want 1/4", ImemReqValid, ImemReqAddr); end
      checks++; if (CurrentPC !== 64'h4) begin errors++; $display("FAIL s1_current_pc got %h want 4", CurrentPC); end
      checks++; if (InstrValid !== 1'b0) begin errors++; $display("FAIL s1_instr_valid got %b want 0", InstrValid); end
      cycle(); #1;
      checks++; if (InstrValid !== 1'b1 || InstrPC !== 64'h0 || Instr !== 32'h1300_0000) begin errors++; $display("FAIL s2_head got %b/%h/%h want 1/0/13000000", InstrValid, InstrPC, Instr); end
      checks++; if (ImemReqValid !== 1'b0) begin errors++; $display("FAIL s2_no_credit got %b want 0", ImemReqValid); end
      cycle();
      exp_a = 64'h8;
      exp_p = 64'h4;
      for (int i = 0; i < 10; i++) begin
         #1;
         if (ImemReqValid) begin
            checks++; if (ImemReqAddr !== exp_a) begin errors++; $display("FAIL stream_addr got %h want %h", ImemReqAddr, exp_a); end
            exp_a = exp_a + 64'd4;
         end
         if (InstrValid) begin
            checks++; if (InstrPC !== exp_p || Instr !== (32'h1300_0000 | exp_p[31:0])) begin errors++; $display("FAIL stream_instr got %h/%h want %h", InstrPC, Instr, exp_p); end
            exp_p = exp_p + 64'd4;
         end
         cycle();
      end
      checks++; if (exp_a !== 64'd36) begin errors++; $display("FAIL stream_req_count next addr %h want 24", exp_a); end
      checks++; if (exp_p !== 64'd32) begin errors++; $display("FAIL stream_pop_count next pc %h want 20", exp_p); end
   endtask

   task automatic test_backpressure();
      int nacc;
      InstrReady = 1'b0; ImemReqReady = 1'b1; resp_en = 1'b1;
      do_reset();
      Reset_L = 1'b1;
      nacc = 0;
      for (int i = 0; i < 10; i++) begin
         #1;
         if (ImemReqValid && ImemReqReady) nacc++;
         cycle();
      end
      #1;
      checks++; if (nacc != 2) begin errors++; $display("FAIL bp_accepts got %0d want 2", nacc); end
      checks++; if (ImemReqValid !== 1'b0) begin errors++; $display("FAIL bp_req_valid got %b want 0", ImemReqValid); end
      checks++; if (InstrValid !== 1'b1 || InstrPC !== 64'h0 || Instr !== 32'h1300_0000) begin errors++; $display("FAIL bp_head0 got %b/%h/%h want 1/0/13000000", InstrValid, InstrPC, Instr); end
      InstrReady = 1'b1;
      cycle(); #1;
      checks++; if (InstrValid !== 1'b1 || InstrPC !== 64'h4 || Instr !== 32'h1300_0004) begin errors++; $display("FAIL bp_head4 got %b/%h/%h want 1/4/13000004", InstrValid, InstrPC, Instr); end
      checks++; if (ImemReqValid !== 1'b1 || ImemReqAddr !== 64'h8) begin errors++; $display("FAIL bp_resume got %b/%h want 1/8", ImemReqValid, ImemReqAddr); end
   endtask

   task automatic test_flush();
      resp_en = 1'b0;
      cycle(); #1;
      checks++; if (ImemReqValid !== 1'b1 || ImemReqAddr !== 64'hc) begin errors++; $display("FAIL fl_req12 got %b/%h want 1/c", ImemReqValid, ImemReqAddr); end
      cycle(); #1;
      checks++; if (ImemReqValid !== 1'b0) begin errors++; $display("FAIL fl_two_out got %b want 0", ImemReqValid); end
      Redirect = 1'b1; NextPC = 64'h100; resp_en = 1'b1;
      cycle();
      Redirect = 1'b0; #1;
      checks++; if (CurrentPC !== 64'h100) begin errors++; $display("FAIL fl_current_pc got %h want 100", CurrentPC); end
      checks++; if (ImemReqValid !== 1'b0 || InstrValid !== 1'b0) begin errors++; $display("FAIL fl_resp1 got req %b instr %b want 0/0", ImemReqValid, InstrValid); end
      cycle(); #1;
      checks++; if (ImemReqValid !== 1'b0 || InstrValid !== 1'b0) begin errors++; $display("FAIL fl_resp2 got req %b instr %b want 0/0", ImemReqValid, InstrValid); end
      cycle(); #1;
      checks++; if (ImemReqValid !== 1'b1 || ImemReqAddr !== 64'h100 || InstrValid !== 1'b0) begin errors++; $display("FAIL fl_restart got %b/%h/%b want 1/100/0", ImemReqValid, ImemReqAddr, InstrValid); end
   endtask

   task automatic test_redirect_idle();
      ImemReqReady = 1'b0;
      Redirect = 1'b1; NextPC = 64'h44; #1;
      checks++; if (ImemReqValid !== 1'b0) begin errors++; $display("FAIL ri_masked got %b want 0", ImemReqValid); end
      cycle();
      Redirect = 1'b0; #1;
      checks++; if (ImemReqValid !== 1'b1 || ImemReqAddr !== 64'h44 || CurrentPC !== 64'h44) begin errors++; $display("FAIL ri_44 got %b/%h/%h want 1/44/44", ImemReqValid, ImemReqAddr, CurrentPC); end
      Redirect = 1'b1; NextPC = 64'h103;
      cycle();
      Redirect = 1'b0; #1;
      checks++; if (ImemReqValid !== 1'b1 || ImemReqAddr !== 64'h100 || CurrentPC !== 64'h100) begin errors++; $display("FAIL ri_103 got %b/%h/%h want 1/100/100", ImemReqValid, ImemReqAddr, CurrentPC); end
   endtask

   task automatic test_double_redirect();
      resp_en = 1'b0; ImemReqReady = 1'b1;
      cycle();
      ImemReqReady = 1'b0; Redirect = 1'b1; NextPC = 64'h200;
      cycle(); #1;
      checks++; if (CurrentPC !== 64'h200 || ImemReqValid !== 1'b0) begin errors++; $display("FAIL dr_first got %h/%b want 200/0", CurrentPC, ImemReqValid); end
      NextPC = 64'h300;
      cycle();
      Redirect = 1'b0; #1;
      checks++; if (CurrentPC !== 64'h300 || ImemReqValid !== 1'b0) begin errors++; $display("FAIL dr_second got %h/%b want 300/0", CurrentPC, ImemReqValid); end
      resp_en = 1'b1;
      cycle(); #1;
      checks++; if (ImemReqValid !== 1'b0) begin errors++; $display("FAIL dr_draining got %b want 0", ImemReqValid); end
      cycle(); #1;
      checks++; if (ImemReqValid !== 1'b1 || ImemReqAddr !== 64'h300 || InstrValid !== 1'b0) begin errors++; $display("FAIL dr_restart got %b/%h/%b want 1/300/0", ImemReqValid, ImemReqAddr, InstrValid); end
   endtask

   task automatic test_reset_in_flush();
      ImemReqReady = 1'b1; resp_en = 1'b0;
      cycle();
      ImemReqReady = 1'b0; Redirect = 1'b1; NextPC = 64'h80;
      cycle();
      Redirect = 1'b0; #1;
      checks++; if (ImemReqValid !== 1'b0 || CurrentPC !== 64'h80) begin errors++; $display("FAIL rf_flush got %b/%h want 0/80", ImemReqValid, CurrentPC); end
      Reset_L = 1'b0; #1;
      checks++; if (CurrentPC !== 64'h0 || ImemReqValid !== 1'b0 || InstrValid !== 1'b0 || InstrPC !== 64'h0) begin errors++; $display("FAIL rf_async got %h/%b/%b/%h want 0/0/0/0", CurrentPC, ImemReqValid, InstrValid, InstrPC); end
      cycle();
      cycle();
      Reset_L = 1'b1; resp_en = 1'b1; #1;
      checks++; if (ImemReqValid !== 1'b1 || ImemReqAddr !== 64'h0) begin errors++; $display("FAIL rf_first_req got %b/%h want 1/0", ImemReqValid, ImemReqAddr); end
      cycle(); #1;
      checks++; if (ImemReqAddr !== 64'h0 || InstrValid !== 1'b0) begin errors++; $display("FAIL rf_stale_window got %h/%b want 0/0", ImemReqAddr, InstrValid); end
      ImemReqReady = 1'b1;
      cycle(); #1;
      checks++; if (InstrValid !== 1'b0 || ImemReqAddr !== 64'h4) begin errors++; $display("FAIL rf_stale_ignored got %b/%h want 0/4", InstrValid, ImemReqAddr); end
      cycle(); #1;
      checks++; if (InstrValid !== 1'b1 || InstrPC !== 64'h0 || Instr !== 32'h1300_0000) begin errors++; $display("FAIL rf_first_instr got %b/%h/%h want 1/0/13000000", InstrValid, InstrPC, Instr); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_flush();
      test_redirect_idle();
      test_double_redirect();
      test_reset_in_flush();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
